spi_bus_arbiter: RTL

- Two-master, one-slave arbiter for the internal 32-bit register/memory bus.
- Master 0 is the SPI debug bridge. It uses a pulse interface: one-cycle ren/wen strobes, and it samples rdata several SPI clocks later.
- Master 1 is the CPU. It uses a valid/ready interface.
- The arbiter captures SPI strobes as pending requests, grants masters round-robin, and runs one slave transaction at a time. Read data for each master is registered and held.

---
 rtl/spi_bus_arbiter_pkg.sv | 13 +
 rtl/spi_bus_arbiter_req_capture.sv | 69 ++++++
 rtl/spi_bus_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the two-master SPI/CPU bus arbiter.
package spi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned NUM_MASTERS  = 2;

endpackage

// File: rtl/spi_bus_arbiter_req_capture.sv
// Converts SPI bridge ren/wen strobes into a held pending request with sticky overrun.
module spi_bus_req_capture
    import spi_bus_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ren_i,
    input  logic          wen_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          clr_i,
    output logic          pend_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          overrun_o
);

    logic          pend_q, pend_d;
    logic          we_q, we_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          strobe;
    logic          accept;

    // A strobe on the same edge the pending request retires is a fresh command.
    always_comb begin
        strobe  = ren_i | wen_i;
        accept  = strobe & (~pend_q | clr_i);
        pend_d  = pend_q & ~clr_i;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovr_d   = ovr_q | (ren_i & wen_i) | (strobe & ~accept);
        if (accept) begin
            pend_d  = 1'b1;
            we_d    = wen_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            ovr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            ovr_q   <= ovr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pend_o    = pend_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter: SPI bridge (pulse) and CPU (valid/ready) onto one slave bus.
// Optional slave abort timer and timeout_err port: SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_ren,
    input  logic          m0_wen,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_overrun,
    input  logic          m1_valid,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,
    output logic          s_valid,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ready,
    input  logic [DW-1:0] s_rdata,
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    output logic          timeout_err,
`endif
    output logic          busy
);

    localparam int unsigned GW = $clog2(NUM_MASTERS);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic          s_valid_q, s_valid_d;
    logic          s_we_q, s_we_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          m1_ready_q, m1_ready_d;

    logic          m0_pend, m0_we, m0_clr;
    logic [AW-1:0] m0_addr_r;
    logic [DW-1:0] m0_wdata_r;
    logic          m1_req;
    logic          expire;
    logic          done;
    logic [DW-1:0] bus_rdata;

    spi_bus_req_capture #(
        .AW(AW),
        .DW(DW)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .ren_i    (m0_ren),
        .wen_i    (m0_wen),
        .addr_i   (m0_addr),
        .wdata_i  (m0_wdata),
        .clr_i    (m0_clr),
        .pend_o   (m0_pend),
        .we_o     (m0_we),
        .addr_o   (m0_addr_r),
        .wdata_o  (m0_wdata_r),
        .overrun_o(m0_overrun)
    );

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign expire = (cnt_q == CW'(TIMEOUT)) & ~s_ready;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            tmo_d = tmo_q | expire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign done      = s_ready | expire;
    assign bus_rdata = s_ready ? s_rdata : DW'(BUS_ERR_DATA);
    // m1_valid is still high in the cycle m1_ready pulses; masking it avoids a re-grant.
    assign m1_req    = m1_valid & ~m1_ready_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        s_valid_d    = s_valid_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m1_ready_d   = 1'b0;
        m0_clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_pend | m1_req) begin
                    s_valid_d = 1'b1;
                    if (m1_req & (~m0_pend | (last_grant_q == '0))) begin
                        state_d      = GNT1;
                        last_grant_d = GW'(1);
                        s_we_d       = m1_we;
                        s_addr_d     = m1_addr;
                        s_wdata_d    = m1_wdata;
                    end else begin
                        state_d      = GNT0;
                        last_grant_d = '0;
                        s_we_d       = m0_we;
                        s_addr_d     = m0_addr_r;
                        s_wdata_d    = m0_wdata_r;
                    end
                end
            end
            GNT0: begin
                if (done) begin
                    if (!s_we_q) m0_rdata_d = bus_rdata;
                    m0_clr    = 1'b1;
                    s_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            GNT1: begin
                if (done) begin
                    m1_rdata_d = bus_rdata;
                    m1_ready_d = 1'b1;
                    s_valid_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= '1;
            s_valid_q    <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m1_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            s_valid_q    <= s_valid_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_ready_q   <= m1_ready_d;
        end
    end

    assign s_valid  = s_valid_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_ready = m1_ready_q;
    assign busy     = (state_q != IDLE);

endmodule
